// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types and constants for the SRAM port arbiter: FSM state encoding,
//   requester id type, requester id constants and the round-robin successor
//   helper.
package sram_arb_pkg;

   localparam int NUM_REQ = 3;

   typedef logic [1:0] req_id_t;

   localparam req_id_t ID_BOOT  = 2'd0;  // bootloader write path
   localparam req_id_t ID_FETCH = 2'd1;  // DLX instruction fetch
   localparam req_id_t ID_DATA  = 2'd2;  // debug / data port

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

   // Next requester id in the rotation 0 -> 1 -> 2 -> 0.
   function automatic req_id_t next_id(input req_id_t id);
      return (id == ID_DATA) ? ID_BOOT : req_id_t'(id + 2'd1);
   endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick
//   Combinational winner selection among the eligible requesters.
//   Optional feature macro: SRAM_ARB_RR_EN
//     defined   : round-robin, search starts at the requester after last_winner
//     undefined : fixed priority r0 > r1 > r2, last_winner is ignored
// Ports
//   eligible    in  [NUM_REQ-1:0]  masked request vector
//   last_winner in  req_id_t       previous winner (round-robin pointer)
//   any         out                at least one requester eligible
//   winner      out req_id_t       selected requester (valid when any=1)
module sram_arb_pick
   import sram_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] eligible,
   input  req_id_t            last_winner,
   output logic               any,
   output req_id_t            winner
);

`ifdef SRAM_ARB_RR_EN
   req_id_t c0, c1, c2;

   assign c0 = next_id(last_winner);
   assign c1 = next_id(c0);
   assign c2 = next_id(c1);

   // Later assignments override earlier ones, so c0 (closest to the
   // pointer) has the highest priority.
   always_comb begin
      any    = |eligible;
      winner = c2;
      if (eligible[c1]) winner = c1;
      if (eligible[c0]) winner = c0;
   end
`else
   logic unused_last;
   assign unused_last = ^last_winner;

   always_comb begin
      any    = |eligible;
      winner = ID_DATA;
      if (eligible[ID_FETCH]) winner = ID_FETCH;
      if (eligible[ID_BOOT])  winner = ID_BOOT;
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single sram_fsm request port among three requesters
//   (r0 bootloader write, r1 instruction fetch, r2 debug/data). One
//   transaction at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   Optional feature macro: SRAM_ARB_RR_EN (round-robin instead of fixed
//   priority; adds a last-winner pointer that resets to r2).
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   boot_mode                     1: only r0 eligible; 0: r1/r2 eligible
//   rN_req/we/addr/wdata          requester command, held until rN_gnt
//   rN_gnt                        one-cycle accept pulse (issue cycle)
//   rN_rvalid                     one-cycle read-data-valid pulse
//   rdata                         shared read-data register
//   busy                          transaction in progress
//   sram_mem_wr_en/rd_en          one-cycle strobes to sram_fsm
//   sram_mem_addr/wr_data         latched command, stable ISSUE..DONE
//   sram_mem_rd_data              read data from sram_fsm
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20,
   parameter int SRAM_LAT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  boot_mode,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   input  logic                  r2_req,
   input  logic                  r2_we,
   input  logic [ADDR_WIDTH-1:0] r2_addr,
   input  logic [DATA_WIDTH-1:0] r2_wdata,
   output logic                  r0_gnt,
   output logic                  r1_gnt,
   output logic                  r2_gnt,
   output logic                  r0_rvalid,
   output logic                  r1_rvalid,
   output logic                  r2_rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  sram_mem_wr_en,
   output logic                  sram_mem_rd_en,
   output logic [ADDR_WIDTH-1:0] sram_mem_addr,
   output logic [DATA_WIDTH-1:0] sram_mem_wr_data,
   input  logic [DATA_WIDTH-1:0] sram_mem_rd_data
);

   localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_LAT - 1);

   arb_state_t           state;
   logic [CNT_W-1:0]     cnt;
   req_id_t              id_q;
   logic                 we_q;
   logic                 rv_pend;
   logic [NUM_REQ-1:0]   gnt_q, rvalid_q;
   logic [NUM_REQ-1:0]   req_v, eligible;
   logic                 any;
   req_id_t              winner, last_winner;
   logic                 sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   assign req_v    = {r2_req, r1_req, r0_req};
   // Boot mode gives r0 the port exclusively; otherwise r0 is locked out.
   assign eligible = boot_mode ? (req_v & 3'b001) : (req_v & 3'b110);

   sram_arb_pick u_pick (
      .eligible    (eligible),
      .last_winner (last_winner),
      .any         (any),
      .winner      (winner)
   );

`ifdef SRAM_ARB_RR_EN
   req_id_t rr_ptr;
   assign last_winner = rr_ptr;
`else
   assign last_winner = ID_DATA;
`endif

   always_comb begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      case (winner)
         ID_FETCH: begin sel_we = r1_we; sel_addr = r1_addr; sel_wdata = r1_wdata; end
         ID_DATA:  begin sel_we = r2_we; sel_addr = r2_addr; sel_wdata = r2_wdata; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         id_q             <= ID_BOOT;
         we_q             <= 1'b0;
         rv_pend          <= 1'b0;
         gnt_q            <= '0;
         rvalid_q         <= '0;
         rdata            <= '0;
         busy             <= 1'b0;
         sram_mem_wr_en   <= 1'b0;
         sram_mem_rd_en   <= 1'b0;
         sram_mem_addr    <= '0;
         sram_mem_wr_data <= '0;
`ifdef SRAM_ARB_RR_EN
         rr_ptr           <= ID_DATA;
`endif
      end else begin
         gnt_q          <= '0;
         sram_mem_wr_en <= 1'b0;
         sram_mem_rd_en <= 1'b0;
         rv_pend        <= 1'b0;
         // rdata was captured on the DONE edge; the owner pulse follows one
         // cycle later. id_q still holds the owner here because a new
         // winner only overwrites it on this same edge.
         rvalid_q       <= rv_pend ? (NUM_REQ'(1) << id_q) : '0;
         case (state)
            IDLE: if (any) begin
               // Strobe and grant are registered so they are high during ISSUE.
               state            <= ISSUE;
               busy             <= 1'b1;
               id_q             <= winner;
               we_q             <= sel_we;
               sram_mem_addr    <= sel_addr;
               sram_mem_wr_data <= sel_wdata;
               gnt_q            <= NUM_REQ'(1) << winner;
               sram_mem_wr_en   <= sel_we;
               sram_mem_rd_en   <= !sel_we;
`ifdef SRAM_ARB_RR_EN
               rr_ptr           <= winner;
`endif
            end
            ISSUE: begin
               cnt   <= CNT_LOAD;
               state <= (SRAM_LAT == 1) ? DONE : WAIT;
            end
            // SRAM_LAT-1 WAIT cycles put DONE exactly SRAM_LAT after ISSUE.
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= DONE;
            end
            DONE: begin
               if (!we_q) begin
                  rdata   <= sram_mem_rd_data;
                  rv_pend <= 1'b1;
               end
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign {r2_gnt, r1_gnt, r0_gnt}          = gnt_q;
   assign {r2_rvalid, r1_rvalid, r0_rvalid} = rvalid_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

   localparam int LAT = 4;

   typedef struct {
      int          dut;   // 0: LAT=4 instance, 1: LAT=1 instance
      int          kind;  // 0: gnt, 1: rvalid
      int          id;
      int          cyc;
      bit          we;
      logic [19:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t expq[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A (SRAM_LAT=4) and DUT B (SRAM_LAT=1) stimulus
   logic        a_boot, b_boot;
   logic        a_req[3], a_we[3], b_req[3], b_we[3];
   logic [19:0] a_addr[3], b_addr[3];
   logic [31:0] a_wd[3], b_wd[3];

   logic [2:0]  a_gnt, a_rv, b_gnt, b_rv;
   logic [31:0] a_rdata, b_rdata, a_mwd, b_mwd, a_mrd, b_mrd;
   logic [19:0] a_maddr, b_maddr;
   logic        a_busy, b_busy, a_wr_en, a_rd_en, b_wr_en, b_rd_en;

   sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(20), .SRAM_LAT(LAT)) dut_a (
      .clk(clk), .rst(rst), .boot_mode(a_boot),
      .r0_req(a_req[0]), .r0_we(a_we[0]), .r0_addr(a_addr[0]), .r0_wdata(a_wd[0]),
      .r1_req(a_req[1]), .r1_we(a_we[1]), .r1_addr(a_addr[1]), .r1_wdata(a_wd[1]),
      .r2_req(a_req[2]), .r2_we(a_we[2]), .r2_addr(a_addr[2]), .r2_wdata(a_wd[2]),
      .r0_gnt(a_gnt[0]), .r1_gnt(a_gnt[1]), .r2_gnt(a_gnt[2]),
      .r0_rvalid(a_rv[0]), .r1_rvalid(a_rv[1]), .r2_rvalid(a_rv[2]),
      .rdata(a_rdata), .busy(a_busy),
      .sram_mem_wr_en(a_wr_en), .sram_mem_rd_en(a_rd_en),
      .sram_mem_addr(a_maddr), .sram_mem_wr_data(a_mwd), .sram_mem_rd_data(a_mrd));

   sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(20), .SRAM_LAT(1)) dut_b (
      .clk(clk), .rst(rst), .boot_mode(b_boot),
      .r0_req(b_req[0]), .r0_we(b_we[0]), .r0_addr(b_addr[0]), .r0_wdata(b_wd[0]),
      .r1_req(b_req[1]), .r1_we(b_we[1]), .r1_addr(b_addr[1]), .r1_wdata(b_wd[1]),
      .r2_req(b_req[2]), .r2_we(b_we[2]), .r2_addr(b_addr[2]), .r2_wdata(b_wd[2]),
      .r0_gnt(b_gnt[0]), .r1_gnt(b_gnt[1]), .r2_gnt(b_gnt[2]),
      .r0_rvalid(b_rv[0]), .r1_rvalid(b_rv[1]), .r2_rvalid(b_rv[2]),
      .rdata(b_rdata), .busy(b_busy),
      .sram_mem_wr_en(b_wr_en), .sram_mem_rd_en(b_rd_en),
      .sram_mem_addr(b_maddr), .sram_mem_wr_data(b_mwd), .sram_mem_rd_data(b_mrd));

   // SRAM model A: word store; read data valid only in the cycle that lies
   // LAT cycles after the read strobe cycle, garbage otherwise.
   logic [31:0]    mem [int];
   logic [LAT-1:0] rp_a = '0;
   logic [31:0]    rword_a = '0;
   always @(posedge clk) begin
      if (a_wr_en) mem[int'(a_maddr)] = a_mwd;
      if (a_rd_en) rword_a <= mem.exists(int'(a_maddr)) ? mem[int'(a_maddr)] : 32'h0;
      rp_a <= {rp_a[LAT-2:0], a_rd_en};
   end
   assign a_mrd = rp_a[LAT-1] ? rword_a : 32'hBAD0BAD0;

   // SRAM model B (latency 1): fixed word in the cycle after the strobe.
   logic rp_b = 1'b0;
   always @(posedge clk) rp_b <= b_rd_en;
   assign b_mrd = rp_b ? 32'hC0DE0001 : 32'hBAD0BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input int id, input logic req, input logic we,
                        input logic [19:0] addr, input logic [31:0] wd);
      if (d == 0) begin
         a_req[id] = req; a_we[id] = we; a_addr[id] = addr; a_wd[id] = wd;
      end else begin
         b_req[id] = req; b_we[id] = we; b_addr[id] = addr; b_wd[id] = wd;
      end
   endtask

   // Issue one command (called just after a rising edge), push the expected
   // gnt (and rvalid for reads), hold req until gnt, then drop it.
   task automatic do_req(input int d, input int id, input bit we, input logic [19:0] addr,
                         input logic [31:0] wd, input int gcyc, input logic [31:0] rexp,
                         input int rcyc);
      ev_t e;
      int  n;
      bit  got;
      e.dut = d; e.kind = 0; e.id = id; e.cyc = gcyc; e.we = we; e.addr = addr; e.data = wd;
      expq.push_back(e);
      if (!we) begin
         e.kind = 1; e.cyc = rcyc; e.data = rexp;
         expq.push_back(e);
      end
      drive(d, id, 1'b1, we, addr, wd);
      n = 0; got = 0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         got = (d == 0) ? a_gnt[id] : b_gnt[id];
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL gnt_timeout dut=%0d r%0d actual=none required=gnt", d, id);
      end
      @(posedge clk); #1;
      drive(d, id, 1'b0, we, addr, wd);
   endtask

   // Monitor: every gnt / rvalid pulse must match a queued expectation.
   task automatic match(input int d, input int kind, input int id);
      int idx = -1;
      ev_t e;
      for (int i = 0; i < expq.size(); i++)
         if (idx < 0 && expq[i].dut == d && expq[i].kind == kind && expq[i].id == id) idx = i;
      if (idx < 0) begin
         checks++; failures++;
         $display("FAIL unexpected_%s dut=%0d r%0d cyc=%0d actual=pulse required=none",
                  kind ? "rvalid" : "gnt", d, id, cyc);
         return;
      end
      e = expq[idx];
      expq.delete(idx);
      chk($sformatf("%s_cycle_d%0d_r%0d", kind ? "rvalid" : "gnt", d, id), cyc, e.cyc);
      if (kind == 0) begin
         chk($sformatf("wr_en_d%0d_r%0d", d, id), {31'd0, d ? b_wr_en : a_wr_en}, {31'd0, e.we});
         chk($sformatf("rd_en_d%0d_r%0d", d, id), {31'd0, d ? b_rd_en : a_rd_en}, {31'd0, !e.we});
         chk($sformatf("addr_d%0d_r%0d", d, id), {12'd0, d ? b_maddr : a_maddr}, {12'd0, e.addr});
         if (e.we) chk($sformatf("wdata_d%0d_r%0d", d, id), d ? b_mwd : a_mwd, e.data);
      end else begin
         chk($sformatf("rdata_d%0d_r%0d", d, id), d ? b_rdata : a_rdata, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (a_gnt[i]) match(0, 0, i);
            if (a_rv[i])  match(0, 1, i);
            if (b_gnt[i]) match(1, 0, i);
            if (b_rv[i])  match(1, 1, i);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int c0, cnt_g, cnt_b;
      a_boot = 1'b1; b_boot = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(0, i, 1'b0, 1'b0, 20'h0, 32'h0);
         drive(1, i, 1'b0, 1'b0, 20'h0, 32'h0);
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_gnt", {29'd0, a_gnt}, 32'd0);
      chk("rst_rvalid", {29'd0, a_rv}, 32'd0);
      chk("rst_strobes", {30'd0, a_wr_en, a_rd_en}, 32'd0);
      chk("rst_rdata", a_rdata, 32'd0);
      chk("rst_addr", {12'd0, a_maddr}, 32'd0);
      chk("rst_wdata", a_mwd, 32'd0);
      chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // 1: boot-mode write by r0; busy drops SRAM_LAT+2 cycles after req
      c0 = cyc;
      do_req(0, 0, 1'b1, 20'h00010, 32'hDEADBEEF, c0 + 1, 32'h0, 0);
      while (cyc < c0 + LAT + 1) @(negedge clk);
      chk("t1_busy_done", {31'd0, a_busy}, 32'd1);
      @(negedge clk);
      chk("t1_busy_idle", {31'd0, a_busy}, 32'd0);
      @(posedge clk); #1;
      a_boot = 1'b0;
      repeat (4) @(posedge clk); #1;

      // 3: r1 and r2 request in the same cycle
      c0 = cyc;
      fork
         begin
            do_req(0, 1, 1'b1, 20'h00020, 32'h11112222, c0 + 1, 32'h0, 0);
`ifdef SRAM_ARB_RR_EN
            do_req(0, 1, 1'b1, 20'h00021, 32'h11113333, c0 + 13, 32'h0, 0);
`endif
         end
         begin
            do_req(0, 2, 1'b1, 20'h00030, 32'h33334444, c0 + 7, 32'h0, 0);
`ifdef SRAM_ARB_RR_EN
            do_req(0, 2, 1'b1, 20'h00031, 32'h33335555, c0 + 19, 32'h0, 0);
`endif
         end
      join
      repeat (8) @(posedge clk); #1;

      // 2: r1 read returns the word written by r0, SRAM_LAT+3 after req
      c0 = cyc;
      do_req(0, 1, 1'b0, 20'h00010, 32'h0, c0 + 1, 32'hDEADBEEF, c0 + LAT + 3);
      repeat (10) @(posedge clk); #1;

      // 4: masking by boot_mode
      a_req[0] = 1'b1;
      cnt_g = 0; cnt_b = 0;
      repeat (20) begin
         @(negedge clk);
         cnt_g += int'(a_gnt[0]);
         cnt_b += int'(a_busy);
      end
      chk("t4_r0_masked_gnts", cnt_g, 32'd0);
      chk("t4_r0_masked_busy", cnt_b, 32'd0);
      @(posedge clk); #1;
      a_req[0] = 1'b0; a_boot = 1'b1; a_req[1] = 1'b1;
      cnt_g = 0;
      repeat (20) begin
         @(negedge clk);
         cnt_g += int'(a_gnt[1]);
      end
      chk("t4_r1_masked_gnts", cnt_g, 32'd0);
      @(posedge clk); #1;
      a_req[1] = 1'b0; a_boot = 1'b0;
      repeat (3) @(posedge clk); #1;

      // 5: reset during WAIT of an r2 read discards it
      c0 = cyc;
      drive(0, 2, 1'b0, 1'b0, 20'h00030, 32'h0);
      begin
         ev_t e;
         e.dut = 0; e.kind = 0; e.id = 2; e.cyc = c0 + 1; e.we = 1'b0; e.addr = 20'h00030; e.data = 32'h0;
         expq.push_back(e);
      end
      a_req[2] = 1'b1;
      @(posedge clk); #1;
      a_req[2] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_busy_after_rst", {31'd0, a_busy}, 32'd0);
      repeat (15) @(posedge clk); #1;
      c0 = cyc;
      do_req(0, 1, 1'b0, 20'h00010, 32'h0, c0 + 1, 32'hDEADBEEF, c0 + LAT + 3);
      repeat (10) @(posedge clk); #1;

      // 6: SRAM_LAT=1 instance, rvalid 4 cycles after req
      c0 = cyc;
      do_req(1, 1, 1'b0, 20'h00044, 32'h0, c0 + 1, 32'hC0DE0001, c0 + 4);
      repeat (10) @(posedge clk);

      foreach (expq[i]) begin
         checks++; failures++;
         $display("FAIL missing_%s dut=%0d r%0d actual=none required=cyc%0d",
                  expq[i].kind ? "rvalid" : "gnt", expq[i].dut, expq[i].id, expq[i].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
